// File: rtl/glitch_safe_pulse_tx.sv
// glitch_safe_pulse_tx: turns single-cycle event strobes into output pulses of
// exactly HIGH_CYC cycles high and at least LOW_CYC cycles low, queueing events
// that arrive while a pulse is in flight (saturating pending counter).
// Optional build macro GPTX_OVF_STICKY_EN: overflow becomes sticky and adds
// the ovf_clr input; otherwise overflow is a one-cycle pulse per dropped event.
module glitch_safe_pulse_tx #(
  parameter int unsigned HIGH_CYC = 5,
  parameter int unsigned LOW_CYC  = 5,
  parameter int unsigned CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ev_in,
`ifdef GPTX_OVF_STICKY_EN
  input  logic             ovf_clr,
`endif
  output logic             data_out,
  output logic             busy,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             overflow
);

  localparam int unsigned MAX_CYC = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC) + 1;

  localparam logic [TMR_W-1:0] HIGH_LOAD = TMR_W'(HIGH_CYC - 1);
  localparam logic [TMR_W-1:0] LOW_LOAD  = TMR_W'(LOW_CYC - 1);
  localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             start;
  logic             consume;
  logic             drop;

  // A pulse can start when a fresh strobe arrives or one is already queued.
  assign start = ev_in | (pend_q != '0);

  // Next-state: timer counts down the remaining cycles of the current phase.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    consume = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HIGH;
          timer_d = HIGH_LOAD;
          consume = 1'b1;
        end
      end
      HIGH: begin
        if (timer_q == '0) begin
          state_d = LOW;
          timer_d = LOW_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      LOW: begin
        if (timer_q == '0) begin
          if (start) begin
            state_d = HIGH;
            timer_d = HIGH_LOAD;
            consume = 1'b1;
          end else begin
            state_d = IDLE;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
    data_d = (state_d == HIGH);
  end

  // Pending accounting: consume and a simultaneous strobe cancel out.
  always_comb begin
    pend_d = pend_q;
    drop   = 1'b0;
    if (consume) begin
      if ((pend_q != '0) && !ev_in) begin
        pend_d = pend_q - 1'b1;
      end
    end else if (ev_in) begin
      if (pend_q == PEND_MAX) begin
        drop = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end
  end

  // Overflow flag: sticky (set beats clear) or a one-cycle drop pulse.
  always_comb begin
`ifdef GPTX_OVF_STICKY_EN
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
`else
    ovf_d = drop;
`endif
  end

  // State and output registers; reset aborts any pulse and drops the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      data_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out = data_q;
  assign busy     = (state_q != IDLE);
  assign pend_cnt = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_glitch_safe_pulse_tx.sv
// Bench for glitch_safe_pulse_tx: two instances (default 5/5/3 and 1/1/2),
// directed scenarios plus randomized strobes, checked against a schedule model
// that assigns each accepted event a pulse start cycle.
module tb_glitch_safe_pulse_tx;

  localparam int unsigned H0 = 5, L0 = 5, C0 = 3;
  localparam int unsigned H1 = 1, L1 = 1, C1 = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ev    [2];
  logic          clr;
  logic          dout  [2];
  logic          busyv [2];
  logic          ovfv  [2];
  logic [C0-1:0] p0;
  logic [C1-1:0] p1;

  int hc   [2];
  int lc   [2];
  int pmax [2];
  int sq   [2][$];
  bit ovf_m  [2];
  bit d_prev [2];
  int n_acc [2], n_drop [2], n_pulse [2], n_ovf [2], n_ev [2];
  int cyc, n_chk, n_fail;

  always #5 clk = ~clk;

  glitch_safe_pulse_tx #(.HIGH_CYC(H0), .LOW_CYC(L0), .CNT_W(C0)) u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .ev_in    (ev[0]),
`ifdef GPTX_OVF_STICKY_EN
    .ovf_clr  (clr),
`endif
    .data_out (dout[0]),
    .busy     (busyv[0]),
    .pend_cnt (p0),
    .overflow (ovfv[0])
  );

  glitch_safe_pulse_tx #(.HIGH_CYC(H1), .LOW_CYC(L1), .CNT_W(C1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .ev_in    (ev[1]),
`ifdef GPTX_OVF_STICKY_EN
    .ovf_clr  (clr),
`endif
    .data_out (dout[1]),
    .busy     (busyv[1]),
    .pend_cnt (p1),
    .overflow (ovfv[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] pend_of(input int k);
    return (k == 0) ? 32'(p0) : 32'(p1);
  endfunction

  // Model queries: a pulse starting at s is high in [s, s+H) and the block is
  // busy in [s, s+H+L); an accepted event is pending until its start cycle.
  function automatic bit m_data(input int k, input int c);
    for (int i = 0; i < sq[k].size(); i++)
      if (sq[k][i] <= c && c < sq[k][i] + hc[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy(input int k, input int c);
    for (int i = 0; i < sq[k].size(); i++)
      if (sq[k][i] <= c && c < sq[k][i] + hc[k] + lc[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_pend(input int k, input int c);
    int n;
    n = 0;
    for (int i = 0; i < sq[k].size(); i++)
      if (sq[k][i] > c) n++;
    return n;
  endfunction

  // Model update for the edge ending cycle cyc.
  task automatic model_edge(input int k, input bit e, input bit cl);
    int  pa, last, s;
    bit  drop;
    pa   = 0;
    last = -1000000;
    drop = 1'b0;
    for (int i = 0; i < sq[k].size(); i++) begin
      if (sq[k][i] > cyc + 1) pa++;
      if (sq[k][i] > last) last = sq[k][i];
    end
    if (e) begin
      if (pa == pmax[k]) begin
        drop = 1'b1;
        n_drop[k]++;
      end else begin
        s = cyc + 1;
        if (last + hc[k] + lc[k] > s) s = last + hc[k] + lc[k];
        sq[k].push_back(s);
        n_acc[k]++;
      end
    end
`ifdef GPTX_OVF_STICKY_EN
    if (drop) ovf_m[k] = 1'b1;
    else if (cl) ovf_m[k] = 1'b0;
`else
    ovf_m[k] = drop;
`endif
    while (sq[k].size() > 0 && sq[k][0] + hc[k] + lc[k] < cyc) void'(sq[k].pop_front());
  endtask

  // Check current-cycle outputs against the model, then advance one clock.
  task automatic step();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("data_out%0d", k), 32'(dout[k]), 32'(m_data(k, cyc)));
      check($sformatf("busy%0d", k), 32'(busyv[k]), 32'(m_busy(k, cyc)));
      check($sformatf("pend_cnt%0d", k), pend_of(k), 32'(m_pend(k, cyc)));
      check($sformatf("overflow%0d", k), 32'(ovfv[k]), 32'(ovf_m[k]));
      if (dout[k] && !d_prev[k]) n_pulse[k]++;
      d_prev[k] = dout[k];
      if (ovfv[k]) n_ovf[k]++;
      if (ev[k]) n_ev[k]++;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k, ev[k], clr);
    cyc++;
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_data%0d", k), 32'(dout[k]), 32'(0));
      check($sformatf("rst_busy%0d", k), 32'(busyv[k]), 32'(0));
      check($sformatf("rst_pend%0d", k), pend_of(k), 32'(0));
      check($sformatf("rst_ovf%0d", k), 32'(ovfv[k]), 32'(0));
      sq[k].delete();
      ovf_m[k]   = 1'b0;
      d_prev[k]  = 1'b0;
      n_acc[k]   = 0;
      n_drop[k]  = 0;
      n_pulse[k] = 0;
      n_ovf[k]   = 0;
      n_ev[k]    = 0;
      ev[k]      = 1'b0;
    end
    clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc += 2;
  endtask

  task automatic idle(input int n);
    ev[0] = 1'b0;
    ev[1] = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_p, b_o, maxp, d0, d1;
    hc[0] = H0; lc[0] = L0; pmax[0] = (1 << C0) - 1;
    hc[1] = H1; lc[1] = L1; pmax[1] = (1 << C1) - 1;
    n_chk = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b1; clr = 1'b0; ev[0] = 1'b0; ev[1] = 1'b0;
    do_reset();

    // Quiet after reset: nothing may appear.
    idle(20);
    check("idle_pulses", 32'(n_pulse[0]), 32'(0));

    // Single strobe: 5 high, 5 low, busy for 10.
    ev[0] = 1'b1;
    step();
    ev[0] = 1'b0;
    for (int r = 1; r <= 12; r++) begin
      check("single_data", 32'(dout[0]), 32'(r <= 5));
      check("single_busy", 32'(busyv[0]), 32'(r <= 10));
      check("single_pend", 32'(p0), 32'(0));
      step();
    end

    // Three consecutive strobes: back-to-back pulses from the queue.
    for (int r = 0; r < 35; r++) begin
      ev[0] = (r < 3);
      if (r == 2)  check("triple_pend_r2", 32'(p0), 32'(1));
      if (r == 3)  check("triple_pend_r3", 32'(p0), 32'(2));
      if (r == 10) check("triple_gap_low", 32'(dout[0]), 32'(0));
      if (r == 11) check("triple_b2b_high", 32'(dout[0]), 32'(1));
      if (r == 11) check("triple_pend_r11", 32'(p0), 32'(1));
      if (r == 21) check("triple_pend_r21", 32'(p0), 32'(0));
      if (r == 30) check("triple_busy_r30", 32'(busyv[0]), 32'(1));
      if (r == 31) check("triple_busy_r31", 32'(busyv[0]), 32'(0));
      step();
    end

    // Strobe held for 10 cycles: saturation at 7, two drops, 8 pulses.
    b_p = n_pulse[0];
    b_o = n_ovf[0];
    maxp = 0;
    for (int r = 0; r < 100; r++) begin
      ev[0] = (r < 10);
      if (int'(p0) > maxp) maxp = int'(p0);
      step();
    end
    check("sat_peak", 32'(maxp), 32'(7));
    check("sat_pulses", 32'(n_pulse[0] - b_p), 32'(8));
`ifdef GPTX_OVF_STICKY_EN
    check("sat_ovf_sticky", 32'(ovfv[0]), 32'(1));
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("sat_ovf_cleared", 32'(ovfv[0]), 32'(0));
`else
    check("sat_ovf_cycles", 32'(n_ovf[0] - b_o), 32'(2));
`endif

    // Reset in the middle of a pulse with three events queued.
    for (int r = 0; r < 4; r++) begin
      ev[0] = 1'b1;
      step();
    end
    ev[0] = 1'b0;
    check("midrst_pend", 32'(p0), 32'(3));
    check("midrst_high", 32'(dout[0]), 32'(1));
    do_reset();
    idle(30);
    check("midrst_no_pulses", 32'(n_pulse[0]), 32'(0));

    // 1/1 instance: four strobes give an alternating output.
    b_o = n_ovf[1];
    maxp = 0;
    for (int r = 0; r < 12; r++) begin
      ev[1] = (r < 4);
      if (r >= 1 && r <= 8) check("tog_data", 32'(dout[1]), 32'((r <= 7) && (r % 2 == 1)));
      if (int'(p1) > maxp) maxp = int'(p1);
      step();
    end
    check("tog_peak", 32'(maxp), 32'(2));
    check("tog_ovf", 32'(n_ovf[1] - b_o), 32'(0));

    // Randomized strobe density per block, with one reset in the middle.
    for (int blk = 0; blk < 15; blk++) begin
      d0 = $urandom_range(0, 100);
      d1 = $urandom_range(0, 100);
      for (int i = 0; i < 100; i++) begin
        ev[0] = ($urandom_range(0, 99) < d0);
        ev[1] = ($urandom_range(0, 99) < d1);
        clr   = ($urandom_range(0, 15) == 0);
        step();
      end
      if (blk == 7) do_reset();
    end
    clr = 1'b0;
    idle(120);
    for (int k = 0; k < 2; k++)
      check($sformatf("pulse_total%0d", k), 32'(n_pulse[k]), 32'(n_ev[k] - n_drop[k]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/glitch_safe_pulse_tx.md
Name: glitch_safe_pulse_tx

Overview:
- Transmit-side counterpart to the input glitch filter.
- Converts single-cycle event strobes into output pulses with guaranteed minimum high and low widths, so a downstream N-cycle stability filter never rejects them.
- Queues events that arrive while a pulse is in flight, up to a saturating pending count; flags overflow on drops.
- Sits at chip outputs or clock-domain-crossing boundaries, driving lines that are glitch-filtered on the far side.

Parameters:
HIGH_CYC, 5, data_out high width in clk cycles; must be >= 1 and must exceed the receiver filter depth.
LOW_CYC, 5, minimum data_out low width between pulses in clk cycles; >= 1.
CNT_W, 3, pending-event counter width; capacity 2^CNT_W-1.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ev_in  input  1  event strobe, one event per high cycle
data_out  output  1  conditioned pulse output, registered
busy  output  1  high when state != IDLE
pend_cnt  output  CNT_W  events accepted but not yet started
overflow  output  1  event dropped (see Optional Feature)
ovf_clr  input  1  present only with GPTX_OVF_STICKY_EN; clears sticky overflow

Behaviour:
- Reset (async, rst_n low): state IDLE; data_out 0, busy 0, pend_cnt 0, overflow 0, timer 0. Reset mid-pulse aborts immediately; queued events are discarded.
- States: IDLE, HIGH, LOW. Timer width is $clog2 of max(HIGH_CYC, LOW_CYC) plus 1.
- "start" condition: (ev_in == 1) or (pend_cnt > 0).
- IDLE:
  - If start at a clk edge, go to HIGH and load the timer; data_out is 1 from that edge. Latency from ev_in sampled to data_out high is 1 cycle.
  - When pend_cnt == 0, ev_in is consumed directly and not counted.
  - When pend_cnt > 0, one pending event is consumed. A simultaneous ev_in is queued, so the net pend_cnt is unchanged.
- HIGH: data_out is 1 for exactly HIGH_CYC cycles, then go to LOW.
- LOW:
  - data_out is 0 for exactly LOW_CYC cycles.
  - On the last LOW cycle: if start, go directly to HIGH (back-to-back, no idle gap), consuming an event under the same rules as IDLE; otherwise go to IDLE.
- Event accounting:
  - ev_in while busy and not being consumed: pend_cnt increments.
  - If pend_cnt is already 2^CNT_W-1 with no simultaneous consume, the event is dropped, pend_cnt holds, and overflow is raised.
  - Simultaneous increment and consume at saturation: pend_cnt holds, no overflow.
- pend_cnt never wraps.
- busy is combinational from state; data_out is driven from a register, never decoded combinationally.
- Every emitted pulse is exactly HIGH_CYC wide. Gaps between pulses are >= LOW_CYC.
- Number of pulses equals number of ev_in cycles minus the number of drops.

Optional Feature:
- Macro: GPTX_OVF_STICKY_EN.
- Without it: overflow is a 1-cycle pulse, registered on the edge following the dropped ev_in. ovf_clr does not exist.
- With it: overflow sets on a drop and stays 1 until the clk edge where ovf_clr == 1. If a drop and ovf_clr occur in the same cycle, set wins. Reset clears it.

Test Plan:
- Reset release, ev_in held 0 for 20 cycles -> data_out, busy, pend_cnt and overflow all remain 0.
- Single ev_in pulse at cycle 10 (defaults) -> data_out high cycles 11-15, low from 16; busy high cycles 11-20; pend_cnt stays 0.
- Three ev_in strobes on consecutive cycles 10, 11, 12:
  - pend_cnt reads 1 then 2.
  - Three pulses of 5 high with exactly 5 low between them, back-to-back with no IDLE gap.
  - pend_cnt decrements at cycles 21 and 31.
  - busy falls at cycle 41.
- ev_in held high 10 cycles from an IDLE start (CNT_W=3):
  - pend_cnt saturates at 7.
  - Exactly 2 overflow pulses (or, with the macro, a sticky 1 that clears after ovf_clr).
  - 8 output pulses in total.
- rst_n asserted mid-HIGH with pend_cnt = 3 -> all outputs 0 immediately. After release, no pulses unless new ev_in arrives.
- HIGH_CYC=1, LOW_CYC=1, ev_in strobes every cycle for 4 cycles -> data_out toggles 1,0,1,0,1,0,1; pend_cnt peaks at 2; no overflow.
